key_press_counter: RTL and testbench

//  Board-side consumer of the push-button inputs: synchronises and debounces
//  KEY[1:0] (active-low), turns each debounced press into a one-cycle pulse,
//  and drives LEDR with a wrapping up/down press count (KEY[0] up, KEY[1] down).

---
 rtl/key_press_counter_pkg.sv | 10 +
 rtl/key_debounce.sv | 62 ++++++
 rtl/key_press_counter.sv | 45 ++++
 tb/tb_key_press_counter.sv | 119 +++++++++++
 4 files changed

// File: rtl/key_press_counter_pkg.sv
// Shared definitions for push-button consumers on the practice board.
// KEY pins are active-low. The default debounce window is 10 ms at 50 MHz.
package key_press_counter_pkg;

    localparam logic KEY_PRESSED             = 1'b0;
    localparam logic KEY_RELEASED            = 1'b1;
    localparam int   DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int   DEFAULT_LED_W           = 10;

endpackage

// File: rtl/key_debounce.sv
// Handles one push button: a two-flop synchroniser, a debounce filter, and a
// detector that flags the cycle on which the filtered level becomes pressed.
// The press output is combinational. The parent module registers it.
module key_debounce
    import key_press_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous pin into the clock domain. The flops idle at the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= KEY_RELEASED;
            sync2 <= KEY_RELEASED;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // The stable level changes only after the new level holds for DEBOUNCE_CYCLES
    // consecutive edges. A glitch back to the stable level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= KEY_RELEASED;
            cnt    <= '0;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Keep last cycle's stable level so that the press edge can be detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d <= KEY_RELEASED;
        end else begin
            stable_d <= stable;
        end
    end

    assign press = (stable_d != KEY_PRESSED) && (stable == KEY_PRESSED);

endmodule

// File: rtl/key_press_counter.sv
// Debounces KEY[1:0] and drives LEDR with a wrapping press count.
// KEY[0] counts up and KEY[1] counts down. key_press carries one pulse per press.
module key_press_counter
    import key_press_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LED_W           = DEFAULT_LED_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       KEY,
    output logic [LED_W-1:0] LEDR,
    output logic [1:0]       key_press
);

    logic [1:0] press_evt;

    for (genvar i = 0; i < 2; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk  (clk),
            .rst  (rst),
            .key_n(KEY[i]),
            .press(press_evt[i])
        );
    end

    // Register the press pulses. Update the count on the same edge. Presses on
    // both keys in the same cycle cancel, so the count holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_press <= 2'b00;
            LEDR      <= '0;
        end else begin
            key_press <= press_evt;
            case (press_evt)
                2'b01:   LEDR <= LEDR + LED_W'(1);
                2'b10:   LEDR <= LEDR - LED_W'(1);
                default: LEDR <= LEDR;
            endcase
        end
    end

endmodule

// File: tb/tb_key_press_counter.sv
// Directed self-checking bench for key_press_counter with DEBOUNCE_CYCLES=4 and LED_W=10.
// With DEBOUNCE_CYCLES=4, a press pulse appears 7 edges after the KEY change is first sampled.
module tb_key_press_counter;

    logic       clk;
    logic       rst;
    logic [1:0] KEY;
    logic [9:0] LEDR;
    logic [1:0] key_press;

    int errors = 0;
    int checks = 0;

    key_press_counter #(
        .DEBOUNCE_CYCLES(4),
        .LED_W          (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .KEY      (KEY),
        .LEDR     (LEDR),
        .key_press(key_press)
    );

    // 20 ns board clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Inputs change on the falling edge, away from the sampling edge
    task automatic apply_stimulus(input logic [1:0] key, input logic r);
        KEY = key;
        rst = r;
    endtask

    task automatic check_output(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d required=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and check outputs after each one. The pulse is
    // expected only on edge pulse_edge (0 means none). LEDR moves from
    // led_before to led_after on that edge.
    task automatic watch(input string tag, input int n, input int pulse_edge,
                         input logic [1:0] pulse_val,
                         input logic [9:0] led_before, input logic [9:0] led_after);
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            @(negedge clk);
            check_output({tag, "_key_press"}, {8'd0, key_press},
                         (e == pulse_edge) ? {8'd0, pulse_val} : 10'd0);
            check_output({tag, "_LEDR"}, LEDR, (e >= pulse_edge) ? led_after : led_before);
        end
    endtask

    initial begin
        apply_stimulus(2'b11, 1'b1);
        @(negedge clk);

        // Reset held for 3 cycles, then released with the keys idle
        watch("reset", 3, 0, 2'b00, 10'd0, 10'd0);
        apply_stimulus(2'b11, 1'b0);
        watch("post_reset", 2, 0, 2'b00, 10'd0, 10'd0);

        // Single KEY[0] press held, then released
        apply_stimulus(2'b10, 1'b0);
        watch("press_up", 20, 7, 2'b01, 10'd0, 10'd1);
        apply_stimulus(2'b11, 1'b0);
        watch("release_up", 20, 0, 2'b00, 10'd1, 10'd1);

        // Bouncy KEY[0] never holds long enough to register
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(2'b10, 1'b0);
            watch("bounce_low", 3, 0, 2'b00, 10'd1, 10'd1);
            apply_stimulus(2'b11, 1'b0);
            watch("bounce_high", 1, 0, 2'b00, 10'd1, 10'd1);
        end
        watch("bounce_settle", 10, 0, 2'b00, 10'd1, 10'd1);

        // Wrap below zero, then wrap back above the maximum
        apply_stimulus(2'b11, 1'b1);
        watch("reset_mid", 1, 0, 2'b00, 10'd0, 10'd0);
        apply_stimulus(2'b11, 1'b0);
        apply_stimulus(2'b01, 1'b0);
        watch("wrap_down", 10, 7, 2'b10, 10'd0, 10'd1023);
        apply_stimulus(2'b11, 1'b0);
        watch("wrap_down_rel", 10, 0, 2'b00, 10'd1023, 10'd1023);
        apply_stimulus(2'b10, 1'b0);
        watch("wrap_up", 10, 7, 2'b01, 10'd1023, 10'd0);
        apply_stimulus(2'b11, 1'b0);
        watch("wrap_up_rel", 10, 0, 2'b00, 10'd0, 10'd0);

        // Both keys pressed on the same edge: both pulse and the count holds
        apply_stimulus(2'b00, 1'b0);
        watch("both", 12, 7, 2'b11, 10'd0, 10'd0);
        apply_stimulus(2'b11, 1'b0);
        watch("both_rel", 10, 0, 2'b00, 10'd0, 10'd0);

        // Bring the count to 1 so that the next reset has a visible effect
        apply_stimulus(2'b10, 1'b0);
        watch("pre_hold", 10, 7, 2'b01, 10'd0, 10'd1);
        apply_stimulus(2'b11, 1'b0);
        watch("pre_hold_rel", 10, 0, 2'b00, 10'd1, 10'd1);

        // KEY[0] held through a one-cycle reset on edge 4 of the press
        apply_stimulus(2'b10, 1'b0);
        watch("hold_pre_rst", 3, 0, 2'b00, 10'd1, 10'd1);
        apply_stimulus(2'b10, 1'b1);
        watch("hold_rst", 1, 0, 2'b00, 10'd0, 10'd0);
        apply_stimulus(2'b10, 1'b0);
        watch("hold_post_rst", 12, 7, 2'b01, 10'd0, 10'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
